// File: rtl/mode4_exp_accum_pkg.sv
// rtl/mode4_exp_accum_pkg.sv - shared FP16 format macros, FSM encodings and constants for the mode-4 accumulator
`ifndef MODE4_DEFINES_SV
`define MODE4_DEFINES_SV
`define DATAWIDTH 16
`define MANTISSA 10
`define EXPONENT 5
`define IEEE_COMPLIANCE 1
`define MODE4_LATENCY 4
`define M4_IDLE 2'd0
`define M4_RUN 2'd1
`define M4_DRAIN 2'd2
`endif

package mode4_exp_accum_pkg;

  typedef enum logic [1:0] {
    M4_ST_IDLE  = `M4_IDLE,
    M4_ST_RUN   = `M4_RUN,
    M4_ST_DRAIN = `M4_DRAIN
  } m4_state_e;

  // drain counter is loaded so the row completes exactly MODE4_LATENCY cycles after the last group
  localparam logic [1:0] DRAIN_LOAD = 2'(`MODE4_LATENCY - 1);
  localparam logic [`DATAWIDTH-1:0] FP_ZERO = '0;

  // disabled lanes contribute +0 so they never perturb the sum
  function automatic logic [`DATAWIDTH-1:0] mask_lane(input logic en, input logic [`DATAWIDTH-1:0] v);
    return en ? v : FP_ZERO;
  endfunction

endpackage

// File: rtl/mode4_add_tree4.sv
// rtl/mode4_add_tree4.sv - registered 4-to-1 FP adder tree, fixed order ((0+1)+(2+3))
module mode4_add_tree4
  import mode4_exp_accum_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [3:0]            lane_mask,
  input  logic [`DATAWIDTH-1:0] in0,
  input  logic [`DATAWIDTH-1:0] in1,
  input  logic [`DATAWIDTH-1:0] in2,
  input  logic [`DATAWIDTH-1:0] in3,
  output logic [`DATAWIDTH-1:0] sum,
  output logic                  sum_valid
);
  logic [`DATAWIDTH-1:0] s1_0, s1_1, s1_2, s1_3, s2_a, s2_b;
  logic [`DATAWIDTH-1:0] add01, add23, add_ab;
  logic                  s1_valid, s2_valid;

  mode4_fp_add #(.SIG_WIDTH(`MANTISSA), .EXP_WIDTH(`EXPONENT)) u_add01 (.a(s1_0), .b(s1_1), .z(add01));
  mode4_fp_add #(.SIG_WIDTH(`MANTISSA), .EXP_WIDTH(`EXPONENT)) u_add23 (.a(s1_2), .b(s1_3), .z(add23));
  mode4_fp_add #(.SIG_WIDTH(`MANTISSA), .EXP_WIDTH(`EXPONENT)) u_addab (.a(s2_a), .b(s2_b), .z(add_ab));

  // three register stages: masked capture, pair sums, group sum
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_0 <= '0; s1_1 <= '0; s1_2 <= '0; s1_3 <= '0;
      s2_a <= '0; s2_b <= '0; sum <= '0;
      s1_valid <= 1'b0; s2_valid <= 1'b0; sum_valid <= 1'b0;
    end else begin
      s1_0      <= mask_lane(lane_mask[0], in0);
      s1_1      <= mask_lane(lane_mask[1], in1);
      s1_2      <= mask_lane(lane_mask[2], in2);
      s1_3      <= mask_lane(lane_mask[3], in3);
      s1_valid  <= in_valid;
      s2_a      <= add01;
      s2_b      <= add23;
      s2_valid  <= s1_valid;
      sum       <= add_ab;
      sum_valid <= s2_valid;
    end
  end
endmodule

// File: rtl/mode4_fp_add.sv
// rtl/mode4_fp_add.sv - combinational IEEE binary float adder, round to nearest even
module mode4_fp_add #(
  parameter int SIG_WIDTH = 10,
  parameter int EXP_WIDTH = 5
) (
  input  logic [SIG_WIDTH+EXP_WIDTH:0] a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] b,
  output logic [SIG_WIDTH+EXP_WIDTH:0] z
);
  localparam int MAGW = SIG_WIDTH + EXP_WIDTH;
  localparam int W    = SIG_WIDTH + 4;
  localparam int SHW  = W + (1 << EXP_WIDTH);
  localparam logic [EXP_WIDTH:0] EMAX = (EXP_WIDTH+1)'((1 << EXP_WIDTH) - 1);

  logic [MAGW:0]        x, y;
  logic [EXP_WIDTH-1:0] ex_f, ey_f, ex, ey, d;
  logic [SIG_WIDTH:0]   mx, my;
  logic [SHW-1:0]       sh;
  logic [W-1:0]         x_al, y_al, n;
  logic [W:0]           sum;
  logic [EXP_WIDTH:0]   e;
  logic [MAGW:0]        rw;
  logic                 inc, nan_a, nan_b, inf_a, inf_b;
  int                   lz, sft;

  function automatic int clz(input logic [W-1:0] v);
    int r;
    r = W;
    for (int i = 0; i < W; i++) if (v[i]) r = W - 1 - i;
    return r;
  endfunction

  // align the smaller operand with guard/round/sticky, add, normalize, round, then override specials
  always_comb begin
    x     = (b[MAGW-1:0] > a[MAGW-1:0]) ? b : a;
    y     = (b[MAGW-1:0] > a[MAGW-1:0]) ? a : b;
    ex_f  = x[MAGW-1:SIG_WIDTH];
    ey_f  = y[MAGW-1:SIG_WIDTH];
    ex    = (ex_f == '0) ? EXP_WIDTH'(1) : ex_f;
    ey    = (ey_f == '0) ? EXP_WIDTH'(1) : ey_f;
    mx    = {ex_f != '0, x[SIG_WIDTH-1:0]};
    my    = {ey_f != '0, y[SIG_WIDTH-1:0]};
    d     = ex - ey;
    sh    = {my, {(SHW-SIG_WIDTH-1){1'b0}}} >> d;
    y_al  = {sh[SHW-1 -: W-1], sh[SHW-W] | (|sh[SHW-W-1:0])};
    x_al  = {mx, 3'b000};
    sum   = (x[MAGW] == y[MAGW]) ? ({1'b0, x_al} + {1'b0, y_al}) : ({1'b0, x_al} - {1'b0, y_al});
    lz    = clz(sum[W-1:0]);
    sft   = (lz < int'(ex) - 1) ? lz : int'(ex) - 1;
    if (sum[W]) begin
      n = {sum[W:2], sum[1] | sum[0]};
      e = {1'b0, ex} + (EXP_WIDTH+1)'(1);
    end else begin
      n = sum[W-1:0] << sft;
      e = {1'b0, ex} - (EXP_WIDTH+1)'(sft);
    end
    inc   = n[2] & (n[1] | n[0] | n[3]);
    rw    = {(n[W-1] ? e : '0), n[W-2:3]} + (MAGW+1)'(inc);
    nan_a = (a[MAGW-1:SIG_WIDTH] == '1) && (a[SIG_WIDTH-1:0] != '0);
    nan_b = (b[MAGW-1:SIG_WIDTH] == '1) && (b[SIG_WIDTH-1:0] != '0);
    inf_a = (a[MAGW-1:SIG_WIDTH] == '1) && (a[SIG_WIDTH-1:0] == '0);
    inf_b = (b[MAGW-1:SIG_WIDTH] == '1) && (b[SIG_WIDTH-1:0] == '0);
    z     = {x[MAGW], rw[MAGW-1:0]};
    if (rw[MAGW:SIG_WIDTH] >= EMAX) z = {x[MAGW], {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    if (nan_a || nan_b || (inf_a && inf_b && (a[MAGW] != b[MAGW])))
      z = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
    else if (inf_a) z = a;
    else if (inf_b) z = b;
    else if (sum == '0) z = {a[MAGW] & b[MAGW], {MAGW{1'b0}}};
  end
endmodule

// File: rtl/mode4_exp_accum.sv
// rtl/mode4_exp_accum.sv - row accumulator of 4-lane exponent groups producing the softmax denominator
module mode4_exp_accum
  import mode4_exp_accum_pkg::*;
#(
  parameter int CNTWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  inp_valid,
  input  logic                  inp_last,
  input  logic [3:0]            lane_mask,
  input  logic [`DATAWIDTH-1:0] inp0,
  input  logic [`DATAWIDTH-1:0] inp1,
  input  logic [`DATAWIDTH-1:0] inp2,
  input  logic [`DATAWIDTH-1:0] inp3,
  output logic [`DATAWIDTH-1:0] outp,
  output logic                  outp_valid,
  output logic                  busy,
  output logic [CNTWIDTH-1:0]   group_count
);
  m4_state_e             state;
  logic [1:0]            drain_cnt;
  logic [`DATAWIDTH-1:0] acc, tree_sum, acc_sum;
  logic                  tree_valid, accept;

  assign accept = (state == M4_ST_RUN) && inp_valid;
  assign busy   = (state != M4_ST_IDLE);

  mode4_add_tree4 u_tree (
    .clk(clk), .reset(reset), .in_valid(accept), .lane_mask(lane_mask),
    .in0(inp0), .in1(inp1), .in2(inp2), .in3(inp3),
    .sum(tree_sum), .sum_valid(tree_valid)
  );

  mode4_fp_add #(.SIG_WIDTH(`MANTISSA), .EXP_WIDTH(`EXPONENT)) u_acc_add (.a(acc), .b(tree_sum), .z(acc_sum));

  // row FSM, accumulator in arrival order, group counter and registered row result
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= M4_ST_IDLE;
      drain_cnt   <= '0;
      acc         <= FP_ZERO;
      outp        <= FP_ZERO;
      outp_valid  <= 1'b0;
      group_count <= '0;
    end else begin
      outp_valid <= 1'b0;
      if (tree_valid) acc <= acc_sum;
      case (state)
        M4_ST_IDLE: begin
          if (start) begin
            state       <= M4_ST_RUN;
            acc         <= FP_ZERO;
            group_count <= '0;
          end
        end
        M4_ST_RUN: begin
          if (inp_valid) begin
            group_count <= group_count + CNTWIDTH'(1);
            if (inp_last) begin
              state     <= M4_ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        M4_ST_DRAIN: begin
          drain_cnt <= drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) begin
            state      <= M4_ST_IDLE;
            outp       <= acc_sum;
            outp_valid <= 1'b1;
          end
        end
        default: state <= M4_ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mode4_exp_accum.sv
// tb/tb_mode4_exp_accum.sv - randomized self-checking bench for mode4_exp_accum against a real-arithmetic model
module tb_mode4_exp_accum;
  logic        clk = 1'b0;
  logic        reset, start, inp_valid, inp_last;
  logic [3:0]  lane_mask;
  logic [15:0] inp0, inp1, inp2, inp3;
  logic [15:0] outp;
  logic        outp_valid, busy;
  logic [15:0] group_count;

  mode4_exp_accum #(.CNTWIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .inp_valid(inp_valid), .inp_last(inp_last),
    .lane_mask(lane_mask), .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
    .outp(outp), .outp_valid(outp_valid), .busy(busy), .group_count(group_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] g_lane [64][4];
  logic [3:0]  g_mask [64];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (outp_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    for (int i = 0; i < k; i++) r = r * 2.0;
    for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] v);
    real m;
    int  ef = int'(v[14:10]);
    int  fr = int'(v[9:0]);
    if (ef == 0) m = real'(fr) * pow2(-24);
    else m = real'(1024 + fr) * pow2(ef - 25);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] from_real(input real s);
    real x, q, f;
    int  e, n;
    logic [15:0] bits;
    x = (s < 0.0) ? -s : s;
    e = 1;
    while (e < 30 && x >= pow2(e - 14)) e++;
    q = x / pow2(e - 25);
    n = $rtoi(q);
    f = q - real'(n);
    if (f > 0.5 || (f == 0.5 && (n % 2) == 1)) n++;
    if (((e - 1) * 1024 + n) >= 32'h7C00) bits = 16'h7C00;
    else bits = 16'((e - 1) * 1024 + n);
    bits[15] = (s < 0.0);
    return bits;
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    bit  na = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    bit  nb = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    bit  ia = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    bit  ib = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    real s;
    if (na || nb || (ia && ib && a[15] != b[15])) return 16'h7E00;
    if (ia) return a;
    if (ib) return b;
    s = to_real(a) + to_real(b);
    if (s == 0.0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
    return from_real(s);
  endfunction

  function automatic logic [15:0] model_row(input int n);
    logic [15:0] acc = 16'h0000;
    logic [15:0] l [4];
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) l[k] = g_mask[i][k] ? g_lane[i][k] : 16'h0000;
      acc = m_add(acc, m_add(m_add(l[0], l[1]), m_add(l[2], l[3])));
    end
    return acc;
  endfunction

  function automatic logic [15:0] rand_fp();
    int r = $urandom_range(0, 19);
    if (r < 12) return {1'b0, 5'($urandom_range(5, 15)), 10'($urandom)};
    if (r < 14) return {1'b0, 5'd0, 10'($urandom)};
    if (r == 14) return 16'h0000;
    if (r == 15) return 16'h8000;
    if (r < 18) return {1'b1, 5'($urandom_range(5, 15)), 10'($urandom)};
    return {1'b0, 5'($urandom_range(16, 28)), 10'($urandom)};
  endfunction

  task automatic set_group(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d, input logic [3:0] m);
    g_lane[i][0] = a; g_lane[i][1] = b; g_lane[i][2] = c; g_lane[i][3] = d; g_mask[i] = m;
  endtask

  task automatic drive_lanes(input int i);
    inp0 = g_lane[i][0]; inp1 = g_lane[i][1]; inp2 = g_lane[i][2]; inp3 = g_lane[i][3];
    lane_mask = g_mask[i];
  endtask

  task automatic drive_noise();
    inp0 = rand_fp(); inp1 = rand_fp(); inp2 = rand_fp(); inp3 = rand_fp();
    lane_mask = 4'($urandom);
    inp_valid = 1'($urandom);
    inp_last = 1'($urandom);
  endtask

  // entered at #1 after an edge; start is driven in the current cycle
  task automatic run_row(input string tag, input int n, input int gmin, input int gmax,
                         input bit noise, input bit chain);
    int t_last = 0;
    bit got = 0;
    logic [15:0] exp_v = model_row(n);
    start = 1'b1;
    if (noise) drive_noise(); else inp_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int gaps = $urandom_range(gmin, gmax);
      for (int g = 0; g < gaps; g++) begin
        inp_valid = 1'b0;
        inp_last = 1'b0;
        start = noise ? 1'($urandom) : 1'b0;
        tick();
      end
      drive_lanes(i);
      inp_valid = 1'b1;
      inp_last = (i == n - 1);
      start = noise ? 1'($urandom) : 1'b0;
      t_last = cyc;
      tick();
    end
    start = 1'b0;
    inp_valid = 1'b0;
    inp_last = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (outp_valid === 1'b1) got = 1;
      else begin
        if (noise) drive_noise();
        tick();
      end
    end
    inp_valid = 1'b0;
    inp_last = 1'b0;
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      exp_pulses++;
      check({tag, "_latency"}, 32'(cyc - t_last), 32'd4);
      check({tag, "_outp"}, 32'(outp), 32'(exp_v));
      check({tag, "_count"}, 32'(group_count), 32'(n));
      check({tag, "_busy"}, 32'(busy), 32'd0);
    end
    if (!chain) begin
      tick();
      check({tag, "_pulse_len"}, 32'(outp_valid), 32'd0);
    end
  endtask

  initial begin
    int p0;
    reset = 1'b1; start = 1'b0; inp_valid = 1'b0; inp_last = 1'b0; lane_mask = 4'h0;
    inp0 = 16'h0; inp1 = 16'h0; inp2 = 16'h0; inp3 = 16'h0;
    repeat (3) tick();
    check("rst_outp", 32'(outp), 32'h0);
    check("rst_valid", 32'(outp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(group_count), 32'h0);
    reset = 1'b0;
    tick();

    set_group(0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'hF);
    run_row("one", 1, 0, 0, 0, 0);
    check("one_const", 32'(outp), 32'h4400);

    set_group(1, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'hF);
    run_row("two", 2, 1, 1, 0, 0);
    check("two_const", 32'(outp), 32'h4800);

    set_group(0, 16'h3C00, 16'h3C00, 16'h4400, 16'h4400, 4'b0011);
    run_row("mask", 1, 0, 0, 0, 0);
    check("mask_const", 32'(outp), 32'h4000);

    set_group(0, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 4'hF);
    p0 = pulses;
    run_row("ign", 1, 2, 3, 1, 0);
    check("ign_const", 32'(outp), 32'h4000);
    check("ign_pulses", 32'(pulses - p0), 32'd1);

    start = 1'b1; tick(); start = 1'b0;
    set_group(0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'hF);
    drive_lanes(0); inp_valid = 1'b1; inp_last = 1'b0; tick();
    inp_last = 1'b1; tick();
    inp_valid = 1'b0; inp_last = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    p0 = pulses;
    repeat (8) tick();
    check("abort_pulses", 32'(pulses - p0), 32'd0);
    check("abort_outp", 32'(outp), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_count", 32'(group_count), 32'h0);
    run_row("post_rst", 1, 0, 1, 0, 0);
    check("post_rst_const", 32'(outp), 32'h4400);

    set_group(0, 16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'hF);
    run_row("inf", 1, 0, 0, 0, 1);
    check("inf_const", 32'(outp), 32'h7C00);
    set_group(0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'hF);
    run_row("chain", 1, 0, 0, 0, 0);
    check("chain_const", 32'(outp), 32'h4400);

    set_group(0, 16'h7C00, 16'h3C00, 16'hFC00, 16'h3C00, 4'hF);
    run_row("nan", 1, 0, 0, 0, 0);
    set_group(0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'hF);
    set_group(1, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 4'h0);
    set_group(2, 16'h3555, 16'hB555, 16'h0001, 16'h03FF, 4'hF);
    run_row("zeros", 3, 0, 1, 0, 0);

    for (int r = 0; r < 30; r++) begin
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        set_group(i, rand_fp(), rand_fp(), rand_fp(), rand_fp(),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      run_row($sformatf("rnd%0d", r), n, 0, 2, 1'($urandom), ($urandom_range(0, 2) == 0));
    end

    repeat (3) tick();
    check("total_pulses", 32'(pulses), 32'(exp_pulses));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mode4_exp_accum.md
Name: mode4_exp_accum

Overview:
- Consumes the four per-cycle exponent results produced by the mode-3 exponent stage. Reduces each 4-lane group with a pipelined FP adder tree and accumulates the group sums across one softmax row.
- Emits the row sum (the softmax denominator) to the downstream ln stage with a one-cycle valid pulse.
- Data format is the codebase's FP16: `DATAWIDTH/`MANTISSA/`EXPONENT/`IEEE_COMPLIANCE from defines.v.

Parameters:
- CNTWIDTH, 16, width of the accepted-group counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new row. Honoured only in IDLE.
- inp_valid  input  1  inp0..inp3 carry a valid group this cycle.
- inp_last  input  1  qualifies inp_valid; marks the final group of the row.
- lane_mask  input  4  per-lane enable; bit i=0 substitutes +0 (16'h0000) for inp_i.
- inp0..inp3  input  `DATAWIDTH each  exponent results from the mode-3 stage.
- outp  output  `DATAWIDTH  row sum.
- outp_valid  output  1  one-cycle pulse; outp holds a new row sum.
- busy  output  1  high when state != IDLE.
- group_count  output  CNTWIDTH  groups accepted in the current or most recent row.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all pipeline valid bits 0, accumulator=+0, outp=16'h0000, outp_valid=0, group_count=0.
  - Reset mid-row aborts the row: no outp_valid is produced for it.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 -> RUN; accumulator<=+0; group_count<=0. inp_valid is ignored.
  - RUN: a group is accepted each cycle inp_valid=1, and group_count increments (wraps at 2^CNTWIDTH). inp_valid=1 with inp_last=1 -> DRAIN and loads drain counter=3. start is ignored. Gaps in inp_valid are allowed.
  - DRAIN: inp_valid and start are ignored. The counter decrements each cycle. At 0 with the final group accumulated -> IDLE, in the same cycle outp_valid rises.
- Pipeline, where T is the acceptance cycle:
  - Edge ending T: masked lanes captured into s1.
  - Edge T+1: s2 <= {s1_0+s1_1, s1_2+s1_3}.
  - Edge T+2: s3 <= s2_a+s2_b.
  - Edge T+3: acc <= acc + s3, only when the s3 valid bit is set.
- Result timing:
  - For the last group accepted in cycle T, outp and outp_valid are visible in cycle T+4. Latency is 4.
  - outp holds its value until the next row completes.
  - outp_valid is high for exactly 1 cycle.
- Throughput: one group per cycle, with no backpressure.
- Arithmetic:
  - All adds use DW_fp_add with `MANTISSA/`EXPONENT/`IEEE_COMPLIANCE and rnd=3'b000 (round to nearest even).
  - Sum order is fixed: ((0+1)+(2+3)), then accumulate in arrival order. This makes results bit-exact reproducible.
  - Special values: inf propagates; inf+(-inf) gives NaN per DW behaviour; +0 + -0 = +0.
- Simultaneous events:
  - start together with inp_valid in IDLE: start is taken, and that group is NOT accepted.
  - start=1 in the same cycle outp_valid=1: state is already IDLE, so start is honoured and the new row begins.
- Masking: lane_mask=4'b0000 with inp_valid still counts as a group and adds +0.

Decomposition:
- defines.v (shared):
  - existing `DATAWIDTH/`MANTISSA/`EXPONENT/`IEEE_COMPLIANCE
  - new `MODE4_LATENCY (4)
  - FSM state encodings `M4_IDLE/`M4_RUN/`M4_DRAIN (2 bits)
- Sub-module mode4_add_tree4: the registered 4-to-1 FP adder tree (s1..s3 with valid bits, 3 DW_fp_add instances).
- The top level holds the FSM, the accumulator adder, the counters and the output registers.

Test Plan:
- Row of one group: start; inp_valid=1, inp_last=1, mask 4'b1111, all lanes 16'h3C00 (1.0) in cycle T -> outp=16'h4400 (4.0), outp_valid=1 only in T+4, group_count=1, busy low from T+4.
- Two-group row with one idle cycle between groups, all lanes 1.0 -> outp=16'h4800 (8.0), group_count=2; latency measured from the last group is 4.
- Masking: one group, lanes {1.0,1.0,4.0,4.0}, lane_mask=4'b0011 -> outp=16'h4000 (2.0).
- Ignored inputs:
  - inp_valid pulses in IDLE and in DRAIN, plus a start pulse during RUN, around a row of {0.5,0.5,0.5,0.5} -> outp=16'h4000.
  - group_count=1, with exactly one outp_valid pulse.
- Reset mid-row: assert reset for 1 cycle after 2 groups -> no outp_valid, outp=16'h0000, busy=0. A following row of all 1.0 gives 16'h4400.
- Special values: lane0=16'h7C00 (+inf), others 1.0 -> outp=16'h7C00. start asserted in the outp_valid cycle begins a new row correctly.
